// File: rtl/seq_timing_ctrl.sv
// Basic-computer sequencer: run flop S, sequence counter SC and IR, with T/D/I/B decode.
// Stalls SC on T1 (and memory-reference T4) until mem_ready; instr_done marks the final T-state.
module seq_timing_ctrl #(
    parameter int HALT_BIT = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      mem_data,
    input  logic             mem_ready,
    output logic [7:0]       T,
    output logic [7:0]       D,
    output logic             I,
    output logic [15:0]      B,
    output logic             running,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        SC_T0 = 3'd0, SC_T1 = 3'd1, SC_T2 = 3'd2, SC_T3 = 3'd3,
        SC_T4 = 3'd4, SC_T5 = 3'd5, SC_T6 = 3'd6, SC_T7 = 3'd7
    } sc_t;

    logic             s_q,   s_d;
    sc_t              sc_q,  sc_d;
    logic [15:0]      ir_q,  ir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done;
    logic [7:0]       d_dec;

    assign d_dec = 8'h01 << ir_q[14:12];

    always_comb begin
        s_d   = s_q;
        sc_d  = sc_q;
        ir_d  = ir_q;
        cnt_d = cnt_q;
        done  = 1'b0;
        if (!s_q) begin
            if (start) begin
                s_d  = 1'b1;
                sc_d = SC_T0;
            end
        end else begin
            case (sc_q)
                SC_T0: sc_d = SC_T1;
                SC_T1: begin
                    if (mem_ready) begin
                        ir_d = mem_data;
                        sc_d = SC_T2;
                    end
                end
                SC_T2: sc_d = SC_T3;
                SC_T3: begin
                    if (d_dec[7]) begin
                        done = 1'b1;
                        sc_d = SC_T0;
                        // Halt only applies to register-reference, not I/O
                        if (!ir_q[15] && ir_q[HALT_BIT]) s_d = 1'b0;
                    end else begin
                        sc_d = SC_T4;
                    end
                end
                SC_T4: begin
                    if (d_dec[7] || mem_ready) sc_d = SC_T5;
                end
                SC_T5: begin
                    if (d_dec[6]) begin
                        sc_d = SC_T6;
                    end else begin
                        done = 1'b1;
                        sc_d = SC_T0;
                    end
                end
                SC_T6: begin
                    done = 1'b1;
                    sc_d = SC_T0;
                end
                default: sc_d = SC_T0;
            endcase
        end
        if (done) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q   <= 1'b0;
            sc_q  <= SC_T0;
            ir_q  <= 16'h0000;
            cnt_q <= '0;
        end else begin
            s_q   <= s_d;
            sc_q  <= sc_d;
            ir_q  <= ir_d;
            cnt_q <= cnt_d;
        end
    end

    assign T          = s_q ? (8'h01 << sc_q) : 8'h00;
    assign D          = d_dec;
    assign I          = ir_q[15];
    assign B          = ir_q;
    assign running    = s_q;
    assign instr_done = done & ~rst;
    assign instr_cnt  = cnt_q;

endmodule

// File: tb/tb_seq_timing_ctrl.sv
// Directed bench for seq_timing_ctrl with hand-computed T/D/B/counter expectations.
module tb_seq_timing_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, mem_ready;
    logic [15:0] mem_data;
    logic [7:0]  T, D;
    logic        I, running, instr_done;
    logic [15:0] B, instr_cnt;

    int checks   = 0;
    int failures = 0;

    seq_timing_ctrl #(.HALT_BIT(0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_data(mem_data),
        .mem_ready(mem_ready), .T(T), .D(D), .I(I), .B(B),
        .running(running), .instr_done(instr_done), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Step one cycle then check T and instr_done of the new cycle
    task automatic step_chk(input string tag, input logic [7:0] exp_t, input logic exp_done);
        tick();
        chk({tag, "_T"}, {24'd0, T}, {24'd0, exp_t});
        chk({tag, "_done"}, {31'd0, instr_done}, {31'd0, exp_done});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mem_ready = 1'b0; mem_data = 16'h0000;
        // 1. reset and start
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_T", {24'd0, T}, 32'h00);
        chk("rst_running", {31'd0, running}, 32'd0);
        chk("rst_cnt", {16'd0, instr_cnt}, 32'd0);
        chk("rst_D", {24'd0, D}, 32'h01);
        chk("rst_B", {16'd0, B}, 32'h0000);
        chk("rst_done", {31'd0, instr_done}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_T", {24'd0, T}, 32'h01);
        chk("start_running", {31'd0, running}, 32'd1);

        // 2. register-reference 7020
        mem_ready = 1'b1; mem_data = 16'h7020;
        step_chk("rr_t1", 8'h02, 1'b0);
        step_chk("rr_t2", 8'h04, 1'b0);
        chk("rr_D", {24'd0, D}, 32'h80);
        chk("rr_I", {31'd0, I}, 32'd0);
        chk("rr_B", {16'd0, B}, 32'h7020);
        step_chk("rr_t3", 8'h08, 1'b1);
        chk("rr_cnt_pre", {16'd0, instr_cnt}, 32'd0);
        step_chk("rr_t0", 8'h01, 1'b0);
        chk("rr_cnt", {16'd0, instr_cnt}, 32'd1);

        // 3. ADD (D1) with stalls: T1 held 4 cycles, T4 held 3 cycles
        mem_data = 16'h1123; mem_ready = 1'b0;
        step_chk("add_t1a", 8'h02, 1'b0);
        step_chk("add_t1b", 8'h02, 1'b0);
        step_chk("add_t1c", 8'h02, 1'b0);
        step_chk("add_t1d", 8'h02, 1'b0);
        mem_ready = 1'b1;
        step_chk("add_t2", 8'h04, 1'b0);
        chk("add_D", {24'd0, D}, 32'h02);
        chk("add_B", {16'd0, B}, 32'h1123);
        step_chk("add_t3", 8'h08, 1'b0);
        mem_ready = 1'b0;
        step_chk("add_t4a", 8'h10, 1'b0);
        step_chk("add_t4b", 8'h10, 1'b0);
        step_chk("add_t4c", 8'h10, 1'b0);
        mem_ready = 1'b1;
        step_chk("add_t5", 8'h20, 1'b1);
        step_chk("add_t0", 8'h01, 1'b0);
        chk("add_cnt", {16'd0, instr_cnt}, 32'd2);

        // 4. D6 instruction
        mem_data = 16'h6200;
        step_chk("d6_t1", 8'h02, 1'b0);
        step_chk("d6_t2", 8'h04, 1'b0);
        chk("d6_D", {24'd0, D}, 32'h40);
        step_chk("d6_t3", 8'h08, 1'b0);
        step_chk("d6_t4", 8'h10, 1'b0);
        step_chk("d6_t5", 8'h20, 1'b0);
        step_chk("d6_t6", 8'h40, 1'b1);
        step_chk("d6_t0", 8'h01, 1'b0);
        chk("d6_cnt", {16'd0, instr_cnt}, 32'd3);

        // 5. halt with start held high through T3
        mem_data = 16'h7001; start = 1'b1;
        step_chk("hlt_t1", 8'h02, 1'b0);
        step_chk("hlt_t2", 8'h04, 1'b0);
        step_chk("hlt_t3", 8'h08, 1'b1);
        tick();
        start = 1'b0;
        chk("hlt_T", {24'd0, T}, 32'h00);
        chk("hlt_running", {31'd0, running}, 32'd0);
        chk("hlt_cnt", {16'd0, instr_cnt}, 32'd4);
        step_chk("hlt_idle", 8'h00, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_T", {24'd0, T}, 32'h01);

        // 6. reset during T4 of a D0 instruction
        mem_data = 16'h0000;
        step_chk("d0_t1", 8'h02, 1'b0);
        step_chk("d0_t2", 8'h04, 1'b0);
        chk("d0_D", {24'd0, D}, 32'h01);
        step_chk("d0_t3", 8'h08, 1'b0);
        step_chk("d0_t4", 8'h10, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_T", {24'd0, T}, 32'h00);
        chk("mrst_running", {31'd0, running}, 32'd0);
        chk("mrst_B", {16'd0, B}, 32'h0000);
        chk("mrst_cnt", {16'd0, instr_cnt}, 32'd0);
        chk("mrst_done", {31'd0, instr_done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
